// File: rtl/tour_cmd_pkg.sv
// Shared types and constants for the Knight tour command scheduler:
// FSM state encoding, response/error codes and command word building blocks.
package tour_cmd_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_WAIT_SNT,
      S_WAIT_RESP,
      S_DONE,
      S_ERROR
   } sched_state_t;

   localparam logic [7:0] POS_ACK = 8'hA5;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_TMO  = 2'b01;
   localparam logic [1:0] ERR_NACK = 2'b10;
   localparam logic [1:0] ERR_OVF  = 2'b11;

   localparam logic [15:0] CAL_GYRO    = 16'h2000;
   localparam logic [3:0]  MOVE_OPC    = 4'h4;
   localparam logic [3:0]  FANFARE_OPC = 4'h5;

   localparam logic [7:0] NORTH = 8'h00;
   localparam logic [7:0] EAST  = 8'hBF;
   localparam logic [7:0] SOUTH = 8'h7F;
   localparam logic [7:0] WEST  = 8'h3F;

   // Command word layout: {opcode, heading, squares}.
   function automatic logic [15:0] mk_move(input logic [3:0] opc,
                                           input logic [7:0] heading,
                                           input logic [3:0] squares);
      return {opc, heading, squares};
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous DEPTH x W command FIFO with flush; the head word is visible on
// dout whenever the FIFO is not empty (first-word fall-through).
module cmd_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic [W-1:0]           din,
   input  logic                   pop,
   output logic [W-1:0]           dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

   assign dout  = mem[rd_ptr[AW-1:0]];
   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/tour_cmd_sched.sv
// Sequences queued Knight commands into RemoteComm, one at a time, advancing on ACK.
// Optional macro TOUR_CMD_SCHED_RETRY_EN: re-send a failed command up to MAX_RETRY times.
module tour_cmd_sched
   import tour_cmd_pkg::*;
#(
   parameter int DEPTH        = 16,
   parameter int TIMEOUT_CLKS = 5_000_000,
   parameter int MAX_RETRY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic [15:0] push_cmd,
   output logic        full,
   output logic        empty,
   input  logic        start,
   input  logic        abort,
   output logic        snd_cmd,
   output logic [15:0] cmd,
   input  logic        cmd_snt,
   input  logic        resp_rdy,
   input  logic [7:0]  resp,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code,
   output logic [7:0]  cmds_done
);

   localparam int TW = $clog2(TIMEOUT_CLKS + 1);
   localparam int CW = $clog2(DEPTH) + 1;

   sched_state_t    state;
   sched_state_t    state_nx;
   logic [15:0]     fifo_dout;
   logic [CW-1:0]   fifo_cnt;
   logic [TW-1:0]   timer;
   logic            pop;
   logic            start_ok;
   logic            ack;
   logic            nack;
   logic            tmo;
   logic            fail;
   logic            can_retry;
   logic            done_q;

   cmd_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (abort),
      .push  (push),
      .din   (push_cmd),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty),
      .count (fifo_cnt)
   );

   assign start_ok = start && !abort && (state == S_IDLE || state == S_ERROR);
   assign ack      = (state == S_WAIT_RESP) && resp_rdy && (resp == POS_ACK);
   assign nack     = (state == S_WAIT_RESP) && resp_rdy && (resp != POS_ACK);
   // A response landing on the limit cycle wins over the timeout.
   assign tmo      = (state == S_WAIT_RESP) && !resp_rdy && (timer == TW'(TIMEOUT_CLKS - 1));
   assign fail     = nack || tmo;

`ifdef TOUR_CMD_SCHED_RETRY_EN
   localparam int RW = $clog2(MAX_RETRY + 2);
   logic [RW-1:0] retry_cnt;

   always_ff @(posedge clk) begin
      if (rst || state == S_LOAD)
         retry_cnt <= '0;
      else if (fail && can_retry && !abort)
         retry_cnt <= retry_cnt + 1'b1;
   end

   assign can_retry = (retry_cnt < RW'(MAX_RETRY));
`else
   assign can_retry = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:      if (start) state_nx = empty ? S_IDLE : S_LOAD;
         S_LOAD:      state_nx = S_SEND;
         S_SEND:      state_nx = S_WAIT_SNT;
         S_WAIT_SNT:  if (cmd_snt) state_nx = S_WAIT_RESP;
         S_WAIT_RESP: begin
            if (ack)       state_nx = (fifo_cnt != '0) ? S_LOAD : S_DONE;
            else if (fail) state_nx = can_retry ? S_SEND : S_ERROR;
         end
         S_DONE:      state_nx = S_IDLE;
         S_ERROR:     if (start) state_nx = empty ? S_IDLE : S_LOAD;
         default:     state_nx = S_IDLE;
      endcase
      if (abort) state_nx = S_IDLE;
   end

   always_comb begin
      snd_cmd = (state == S_SEND);
      pop     = (state == S_LOAD);
      busy    = !(state == S_IDLE || state == S_ERROR);
      done    = (state == S_DONE) || done_q;
   end

   // cmd only changes in LOAD, so it is stable for the whole transmit/response window.
   always_ff @(posedge clk) begin
      if (rst)               cmd <= 16'h0000;
      else if (state == S_LOAD) cmd <= fifo_dout;
   end

   always_ff @(posedge clk) begin
      if (rst)                     timer <= '0;
      else if (state == S_WAIT_SNT) timer <= '0;
      else if (state == S_WAIT_RESP) timer <= timer + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) done_q <= 1'b0;
      else     done_q <= start_ok && empty;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cmds_done <= '0;
      else if (start_ok)
         cmds_done <= '0;
      else if (ack && !abort && cmds_done != 8'hFF)
         cmds_done <= cmds_done + 1'b1;
   end

   // Later assignments take priority: overflow is reported over a concurrent failure.
   always_ff @(posedge clk) begin
      if (rst) begin
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end else begin
         if (start_ok) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
         end
         if (fail && !can_retry && !abort) begin
            err      <= 1'b1;
            err_code <= nack ? ERR_NACK : ERR_TMO;
         end
         if (push && full && !abort) begin
            err      <= 1'b1;
            err_code <= ERR_OVF;
         end
      end
   end

endmodule

// File: tb/tb_tour_cmd_sched.sv
// Directed bench for tour_cmd_sched: ack path, NACK, timeout boundary, overflow,
// abort, empty start and mid-sequence reset, with hand-computed expectations.
module tb_tour_cmd_sched;

   localparam int TMO = 100;
`ifdef TOUR_CMD_SCHED_RETRY_EN
   localparam int NSEND = 3;
`else
   localparam int NSEND = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        push = 1'b0;
   logic [15:0] push_cmd = '0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        cmd_snt = 1'b0;
   logic        resp_rdy = 1'b0;
   logic [7:0]  resp = '0;
   logic        full, empty, snd_cmd, busy, done, err;
   logic [1:0]  err_code;
   logic [7:0]  cmds_done;
   logic [15:0] cmd;

   int checks = 0;
   int errors = 0;
   int snd_cnt = 0;
   int done_cnt = 0;
   logic [15:0] snd_log [$];
   logic [15:0] exp1 [3] = '{16'h2000, 16'h4002, 16'h5BF1};

   always #5 clk = ~clk;

   tour_cmd_sched #(.DEPTH(16), .TIMEOUT_CLKS(TMO), .MAX_RETRY(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_cmd  (push_cmd),
      .full      (full),
      .empty     (empty),
      .start     (start),
      .abort     (abort),
      .snd_cmd   (snd_cmd),
      .cmd       (cmd),
      .cmd_snt   (cmd_snt),
      .resp_rdy  (resp_rdy),
      .resp      (resp),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_code  (err_code),
      .cmds_done (cmds_done)
   );

   always @(negedge clk) begin
      if (snd_cmd) begin
         snd_cnt++;
         snd_log.push_back(cmd);
      end
      if (done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [15:0] w);
      push = 1'b1;
      push_cmd = w;
      tick();
      push = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_snd(input string tag, output int n);
      n = 0;
      while (!snd_cmd && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) chk({tag, "_snd_wait"}, 32'(snd_cmd), 32'd1);
   endtask

   // RemoteComm model: from the SEND cycle, finish transmitting, then answer b.
   task automatic serve(input logic [7:0] b);
      tick();
      cmd_snt = 1'b1;
      tick();
      cmd_snt = 1'b0;
      tick();
      tick();
      resp_rdy = 1'b1;
      resp = b;
      tick();
      resp_rdy = 1'b0;
      resp = '0;
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog expired");
      $fatal(1, "bench timeout");
   end

   initial begin
      int n, b_snd, b_done, b_log;

      repeat (3) tick();
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", {30'd0, err_code} | 32'(err), 32'd0);
      chk("rst_cmd", 32'(cmd), 32'h0);
      chk("rst_cnt", 32'(cmds_done), 32'd0);
      chk("rst_snd", 32'(snd_cmd), 32'd0);
      rst = 1'b0;
      tick();

      // three acked commands
      for (int i = 0; i < 3; i++) push_word(exp1[i]);
      chk("t1_notempty", 32'(empty), 32'd0);
      b_snd = snd_cnt; b_done = done_cnt; b_log = snd_log.size();
      do_start();
      chk("t1_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 3; i++) begin
         wait_snd("t1", n);
         chk("t1_lat", 32'(n), 32'd1);
         chk("t1_cmd", 32'(cmd), 32'(exp1[i]));
         serve(8'hA5);
      end
      chk("t1_done_now", 32'(done), 32'd1);
      repeat (3) tick();
      chk("t1_snds", 32'(snd_cnt - b_snd), 32'd3);
      chk("t1_dones", 32'(done_cnt - b_done), 32'd1);
      for (int i = 0; i < 3; i++) chk("t1_log", 32'(snd_log[b_log + i]), 32'(exp1[i]));
      chk("t1_cnt", 32'(cmds_done), 32'd3);
      chk("t1_empty", 32'(empty), 32'd1);
      chk("t1_idle", 32'(busy), 32'd0);

      // NACK
      push_word(16'h47F1);
      b_snd = snd_cnt;
      do_start();
      for (int k = 0; k < NSEND; k++) begin
         wait_snd("t2", n);
         chk("t2_cmd", 32'(cmd), 32'h47F1);
         serve(8'h5A);
      end
      chk("t2_err", 32'(err), 32'd1);
      chk("t2_code", 32'(err_code), 32'd2);
      chk("t2_busy", 32'(busy), 32'd0);
      repeat (3) tick();
      chk("t2_snds", 32'(snd_cnt - b_snd), 32'(NSEND));
      chk("t2_cnt", 32'(cmds_done), 32'd0);

      // timeout, resumed from ERROR
      push_word(16'h53F2);
      do_start();
      chk("t3_errclr", 32'(err), 32'd0);
      chk("t3_codeclr", 32'(err_code), 32'd0);
      for (int k = 0; k < NSEND; k++) begin
         wait_snd("t3", n);
         tick();
         cmd_snt = 1'b1;
         tick();
         cmd_snt = 1'b0;
         repeat (TMO - 1) tick();
         chk("t3_pre_err", 32'(err), 32'd0);
         chk("t3_pre_busy", 32'(busy), 32'd1);
         tick();
         if (k == NSEND - 1) begin
            chk("t3_err", 32'(err), 32'd1);
            chk("t3_code", 32'(err_code), 32'd1);
            chk("t3_busy", 32'(busy), 32'd0);
         end else begin
            chk("t3_retry", 32'(snd_cmd), 32'd1);
         end
      end

      // ack on the limit cycle beats the timeout
      push_word(16'h4101);
      do_start();
      wait_snd("t3b", n);
      tick();
      cmd_snt = 1'b1;
      tick();
      cmd_snt = 1'b0;
      repeat (TMO - 1) tick();
      resp_rdy = 1'b1;
      resp = 8'hA5;
      tick();
      resp_rdy = 1'b0;
      chk("t3b_err", 32'(err), 32'd0);
      chk("t3b_done", 32'(done), 32'd1);
      chk("t3b_cnt", 32'(cmds_done), 32'd1);
      tick();

      // overflow while idle
      for (int i = 0; i < 16; i++) push_word(16'h4000 + 16'(i));
      chk("t4_full", 32'(full), 32'd1);
      chk("t4_noerr", 32'(err), 32'd0);
      push_word(16'hDEAD);
      chk("t4_err", 32'(err), 32'd1);
      chk("t4_code", 32'(err_code), 32'd3);
      b_snd = snd_cnt; b_done = done_cnt;
      do_start();
      chk("t4_errclr", 32'(err), 32'd0);
      for (int i = 0; i < 16; i++) begin
         wait_snd("t4", n);
         chk("t4_cmd", 32'(cmd), 32'h4000 + 32'(i));
         serve(8'hA5);
      end
      repeat (3) tick();
      chk("t4_snds", 32'(snd_cnt - b_snd), 32'd16);
      chk("t4_dones", 32'(done_cnt - b_done), 32'd1);
      chk("t4_cnt", 32'(cmds_done), 32'd16);
      chk("t4_empty", 32'(empty), 32'd1);

      // abort in WAIT_RESP of the 2nd command
      for (int i = 0; i < 3; i++) push_word(exp1[i]);
      push_word(16'h47F1);
      b_snd = snd_cnt; b_done = done_cnt;
      do_start();
      wait_snd("t5a", n);
      serve(8'hA5);
      wait_snd("t5b", n);
      tick();
      cmd_snt = 1'b1;
      tick();
      cmd_snt = 1'b0;
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_empty", 32'(empty), 32'd1);
      repeat (4) tick();
      resp_rdy = 1'b1;
      resp = 8'hA5;
      tick();
      resp_rdy = 1'b0;
      repeat (10) tick();
      chk("t5_snds", 32'(snd_cnt - b_snd), 32'd2);
      chk("t5_cnt", 32'(cmds_done), 32'd1);
      chk("t5_dones", 32'(done_cnt - b_done), 32'd0);
      chk("t5_err", 32'(err), 32'd0);

      // start with an empty FIFO
      b_snd = snd_cnt; b_done = done_cnt;
      do_start();
      chk("t6_done", 32'(done), 32'd1);
      chk("t6_busy", 32'(busy), 32'd0);
      tick();
      chk("t6_done_off", 32'(done), 32'd0);
      tick();
      chk("t6_dones", 32'(done_cnt - b_done), 32'd1);
      chk("t6_snds", 32'(snd_cnt - b_snd), 32'd0);
      chk("t6_cnt", 32'(cmds_done), 32'd0);

      // reset mid-WAIT_SNT
      push_word(16'h2000);
      push_word(16'h4002);
      do_start();
      wait_snd("t7", n);
      tick();
      chk("t7_busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      chk("t7_busy", 32'(busy), 32'd0);
      chk("t7_cmd", 32'(cmd), 32'h0);
      chk("t7_empty", 32'(empty), 32'd1);
      chk("t7_cnt", 32'(cmds_done), 32'd0);
      chk("t7_err", {30'd0, err_code} | 32'(err), 32'd0);
      chk("t7_done", 32'(done), 32'd0);
      rst = 1'b0;
      tick();
      chk("t7_snd", 32'(snd_cmd), 32'd0);
      chk("t7_idle", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
